// File: rtl/sdram_pattern_tester.sv
// SDRAM write/read-back pattern tester: writes TEST_LEN pattern words, reads them back,
// compares against the expected pattern after RD_LAT cycles and keeps error/pass statistics.
module sdram_pattern_tester #(
    parameter int DATA_W   = 16,
    parameter int TEST_LEN = 1024,
    parameter int CNT_W    = 11,
    parameter int RD_LAT   = 1
) (
    input  logic              clk_50m,
    input  logic              reset_n,
    input  logic              sdram_init_done,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              loop_en,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              error_flag,
    output logic [15:0]       error_cnt,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_data,
    output logic [15:0]       pass_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic             v;
        logic [CNT_W-1:0] idx;
    } tag_t;

    localparam logic [CNT_W-1:0]  FIRST_IDX = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(TEST_LEN);
    localparam logic [DATA_W-1:0] CHK_ODD   = DATA_W'({((DATA_W + 1) / 2){2'b01}});
    localparam logic [DATA_W-1:0] CHK_EVEN  = ~CHK_ODD;

    // Expected word for 1-based index i under pattern mode m.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [CNT_W-1:0] i);
        logic [DATA_W-1:0] v;
        int unsigned       pos;
        pos = (32'(i) - 32'd1) % 32'(DATA_W);
        case (m)
            2'd0:    v = DATA_W'(i);
            2'd1:    v = ~DATA_W'(i);
            2'd2:    v = DATA_W'(1) << pos;
            default: v = i[0] ? CHK_ODD : CHK_EVEN;
        endcase
        return v;
    endfunction

    state_t           state;
    logic             init_meta;
    logic             init_s;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] idx;
    logic             rd_issue;
    tag_t             pipe [RD_LAT+1];

    logic             cmp_valid;
    logic             cmp_last;
    logic             mismatch;
    logic             abort;
    logic             start_ok;

    assign cmp_valid = pipe[RD_LAT].v;
    assign cmp_last  = cmp_valid && (pipe[RD_LAT].idx == LAST_IDX);
    assign mismatch  = cmp_valid && (rd_data != pattern(mode_q, pipe[RD_LAT].idx));
    assign abort     = (state != ST_IDLE) && !init_s;
    assign start_ok  = start && init_s && (state == ST_IDLE || state == ST_DONE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            init_meta <= 1'b0;
            init_s    <= 1'b0;
        end else begin
            init_meta <= sdram_init_done;
            init_s    <= init_meta;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            mode_q         <= 2'd0;
            idx            <= '0;
            rd_issue       <= 1'b0;
            // NOTE: the tag pipeline is reset, unlike a RAM, so no stale valid can fire a compare.
            for (int k = 0; k <= RD_LAT; k++) pipe[k] <= '0;
            wr_en          <= 1'b0;
            wr_data        <= '0;
            rd_en          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error_flag     <= 1'b0;
            error_cnt      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            pass_cnt       <= '0;
        end else begin
            pipe[0] <= tag_t'{v: 1'b0, idx: idx};
            for (int k = 1; k <= RD_LAT; k++) pipe[k] <= pipe[k-1];

            if (abort) begin
                // Loss of init drops everything in flight but keeps the statistics.
                state    <= ST_IDLE;
                rd_issue <= 1'b0;
                wr_en    <= 1'b0;
                wr_data  <= '0;
                rd_en    <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b0;
                for (int k = 0; k <= RD_LAT; k++) pipe[k] <= '0;
            end else if (start_ok) begin
                state          <= ST_WRITE;
                mode_q         <= mode;
                idx            <= FIRST_IDX;
                rd_issue       <= 1'b0;
                wr_en          <= 1'b0;
                wr_data        <= '0;
                rd_en          <= 1'b0;
                busy           <= 1'b1;
                done           <= 1'b0;
                error_flag     <= 1'b0;
                error_cnt      <= '0;
                first_err_idx  <= '0;
                first_err_data <= '0;
                pass_cnt       <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        wr_en   <= 1'b0;
                        wr_data <= '0;
                        rd_en   <= 1'b0;
                    end
                    ST_WRITE: begin
                        wr_en   <= 1'b1;
                        wr_data <= pattern(mode_q, idx);
                        if (idx == LAST_IDX) begin
                            state    <= ST_READ;
                            idx      <= FIRST_IDX;
                            rd_issue <= 1'b1;
                        end else begin
                            idx <= idx + CNT_W'(1);
                        end
                    end
                    ST_READ: begin
                        wr_en   <= 1'b0;
                        wr_data <= '0;
                        if (rd_issue) begin
                            rd_en   <= 1'b1;
                            pipe[0] <= tag_t'{v: 1'b1, idx: idx};
                            if (idx == LAST_IDX) rd_issue <= 1'b0;
                            else                 idx      <= idx + CNT_W'(1);
                        end else begin
                            rd_en <= 1'b0;
                        end
                        if (mismatch) begin
                            error_flag <= 1'b1;
                            if (error_cnt != 16'hFFFF) error_cnt <= error_cnt + 16'd1;
                            if (!error_flag) begin
                                first_err_idx  <= pipe[RD_LAT].idx;
                                first_err_data <= rd_data;
                            end
                        end
                        if (cmp_last) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
                        end
                    end
                    ST_DONE: begin
                        // Soak mode: this edge doubles as the start edge of the next pass.
                        if (loop_en) begin
                            state   <= ST_WRITE;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                            wr_en   <= 1'b1;
                            wr_data <= pattern(mode_q, FIRST_IDX);
                            idx     <= FIRST_IDX + CNT_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester: pattern passes from a vector table, then
// loop-mode, abort and mid-pass reset sequences against a 2-cycle-latency memory model.
module tb_sdram_pattern_tester;

    logic        clk_50m = 1'b0;
    logic        reset_n = 1'b0;
    logic        sdram_init_done = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        loop_en = 1'b0;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        error_flag;
    logic [15:0] error_cnt;
    logic [4:0]  first_err_idx;
    logic [15:0] first_err_data;
    logic [15:0] pass_cnt;

    int n_pass = 0;
    int n_checks = 0;

    sdram_pattern_tester #(
        .DATA_W(16), .TEST_LEN(16), .CNT_W(5), .RD_LAT(2)
    ) dut (
        .clk_50m        (clk_50m),
        .reset_n        (reset_n),
        .sdram_init_done(sdram_init_done),
        .start          (start),
        .mode           (mode),
        .loop_en        (loop_en),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .busy           (busy),
        .done           (done),
        .error_flag     (error_flag),
        .error_cnt      (error_cnt),
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data),
        .pass_cnt       (pass_cnt)
    );

    always #10 clk_50m = ~clk_50m;

    // Memory model: each write burst restarts at slot 0, each read burst likewise;
    // read data appears two cycles after the rd_en cycle, optionally corrupted.
    logic [15:0] mem [16];
    logic        prev_wr = 1'b0;
    logic        prev_rd = 1'b0;
    int          wa = 0;
    int          ra = 0;
    int          w_slot;
    int          r_slot;
    int          fault_a = 0;
    int          fault_b = 0;
    logic [15:0] l1_d = 16'h0;
    logic [15:0] l2_d = 16'h0;

    assign w_slot  = prev_wr ? wa : 0;
    assign r_slot  = prev_rd ? ra : 0;
    assign rd_data = l2_d;

    always @(posedge clk_50m) begin
        prev_wr <= wr_en;
        prev_rd <= rd_en;
        if (wr_en) begin
            mem[w_slot[3:0]] <= wr_data;
            wa <= w_slot + 1;
        end
        if (rd_en) begin
            l1_d <= mem[r_slot[3:0]] ^ (((r_slot + 1) == fault_a || (r_slot + 1) == fault_b) ? 16'h0100 : 16'h0000);
            ra <= r_slot + 1;
        end else begin
            l1_d <= 16'h0;
        end
        l2_d <= l1_d;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [1:0]  mode;
        int          fault_a;
        int          fault_b;
        logic [15:0] exp_w1;
        logic [15:0] exp_w2;
        logic [15:0] exp_wlast;
        int          exp_errs;
        int          exp_flag_k;
        logic [4:0]  exp_first_idx;
        logic [15:0] exp_first_data;
    } vec_t;

    vec_t vecs [7];

    // One full pass from a start pulse; caller is positioned just after a negedge.
    task automatic run_pass(input vec_t v, input string tag);
        bit          wr_ok = 1;
        bit          rd_ok = 1;
        bit          wz_ok = 1;
        int          done_k = -1;
        int          flag_k = -1;
        logic [15:0] w1 = 16'h0;
        logic [15:0] w2 = 16'h0;
        logic [15:0] wl = 16'h0;
        fault_a = v.fault_a;
        fault_b = v.fault_b;
        mode    = v.mode;
        start   = 1'b1;
        @(posedge clk_50m);
        @(negedge clk_50m);
        start = 1'b0;
        if (wr_en || rd_en) begin wr_ok = 0; rd_ok = 0; end
        for (int k = 1; k <= 60 && done_k < 0; k++) begin
            @(negedge clk_50m);
            if (wr_en !== (k >= 1 && k <= 16)) wr_ok = 0;
            if (rd_en !== (k >= 17 && k <= 32)) rd_ok = 0;
            if (!wr_en && wr_data != 16'h0) wz_ok = 0;
            if (k == 1)  w1 = wr_data;
            if (k == 2)  w2 = wr_data;
            if (k == 16) wl = wr_data;
            if (error_flag && flag_k < 0) flag_k = k;
            if (done) done_k = k;
        end
        check({tag, " wr_window"}, 32'(wr_ok), 1);
        check({tag, " rd_window"}, 32'(rd_ok), 1);
        check({tag, " wr_data_idle_zero"}, 32'(wz_ok), 1);
        check({tag, " wr_first"}, 32'(w1), 32'(v.exp_w1));
        check({tag, " wr_second"}, 32'(w2), 32'(v.exp_w2));
        check({tag, " wr_last"}, 32'(wl), 32'(v.exp_wlast));
        check({tag, " done_latency"}, done_k, 35);
        check({tag, " busy_at_done"}, 32'(busy), 0);
        check({tag, " error_cnt"}, 32'(error_cnt), v.exp_errs);
        check({tag, " error_flag"}, 32'(error_flag), 32'(v.exp_errs != 0));
        check({tag, " error_flag_edge"}, flag_k, v.exp_flag_k);
        check({tag, " first_err_idx"}, 32'(first_err_idx), 32'(v.exp_first_idx));
        check({tag, " first_err_data"}, 32'(first_err_data), 32'(v.exp_first_data));
        check({tag, " pass_cnt"}, 32'(pass_cnt), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pk [4];
        int np;
        int low_e;
        bit quiet;

        vecs[0] = '{2'd0,  0, 0, 16'h0001, 16'h0002, 16'h0010, 0, -1,  5'd0,  16'h0000};
        vecs[1] = '{2'd2,  0, 0, 16'h0001, 16'h0002, 16'h8000, 0, -1,  5'd0,  16'h0000};
        vecs[2] = '{2'd3,  0, 0, 16'h5555, 16'hAAAA, 16'hAAAA, 0, -1,  5'd0,  16'h0000};
        vecs[3] = '{2'd1,  0, 0, 16'hFFFE, 16'hFFFD, 16'hFFEF, 0, -1,  5'd0,  16'h0000};
        vecs[4] = '{2'd0,  5, 9, 16'h0001, 16'h0002, 16'h0010, 2, 24,  5'd5,  16'h0105};
        vecs[5] = '{2'd2, 16, 0, 16'h0001, 16'h0002, 16'h8000, 1, 35,  5'd16, 16'h8100};
        vecs[6] = '{2'd3,  1, 0, 16'h5555, 16'hAAAA, 16'hAAAA, 1, 20,  5'd1,  16'h5455};

        // Reset state
        repeat (3) @(negedge clk_50m);
        check("reset_outputs", 32'(|{wr_en, wr_data, rd_en, busy, done, error_flag, error_cnt,
                                     first_err_idx, first_err_data, pass_cnt}), 0);
        reset_n = 1'b1;
        sdram_init_done = 1'b1;
        repeat (4) @(negedge clk_50m);

        for (int i = 0; i < 7; i++) run_pass(vecs[i], $sformatf("vec%0d", i));

        // Loop mode: four passes, fault injected into the fourth
        fault_a = 0; fault_b = 0;
        mode = 2'd0; loop_en = 1'b1; start = 1'b1;
        @(posedge clk_50m);
        @(negedge clk_50m);
        start = 1'b0;
        np = 0;
        for (int k = 1; k <= 200 && np < 4; k++) begin
            @(negedge clk_50m);
            if (done) begin
                pk[np] = k;
                np++;
                if (np == 3) fault_a = 2;
                if (np == 4) loop_en = 1'b0;
            end
        end
        check("loop pulse_count", np, 4);
        check("loop pulse1", pk[0], 35);
        check("loop pulse2", pk[1], 70);
        check("loop pulse3", pk[2], 105);
        check("loop pulse4", pk[3], 140);
        check("loop pass_cnt", 32'(pass_cnt), 4);
        check("loop error_cnt", 32'(error_cnt), 1);
        check("loop first_err_idx", 32'(first_err_idx), 2);
        check("loop first_err_data", 32'(first_err_data), 32'h0102);
        repeat (2) @(negedge clk_50m);
        check("loop done_held", 32'(done), 1);
        check("loop no_restart", 32'(wr_en | busy), 0);
        fault_a = 0;

        // Abort during READ: index 1 compared before abort, index 8 in flight afterwards
        fault_a = 1; fault_b = 8; mode = 2'd0; start = 1'b1;
        @(posedge clk_50m);
        @(negedge clk_50m);
        start = 1'b0;
        repeat (22) @(negedge clk_50m);
        check("abort in_read", 32'(rd_en), 1);
        sdram_init_done = 1'b0;
        low_e = -1;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk_50m);
            if (!rd_en && low_e < 0) low_e = e;
        end
        check("abort rd_en_drop", 32'(low_e >= 1 && low_e <= 3), 1);
        repeat (6) @(negedge clk_50m);
        check("abort quiet_outputs", 32'(|{wr_en, rd_en, busy, done}), 0);
        check("abort error_cnt", 32'(error_cnt), 1);
        check("abort error_flag", 32'(error_flag), 1);
        check("abort first_err_idx", 32'(first_err_idx), 1);
        check("abort first_err_data", 32'(first_err_data), 32'h0101);
        check("abort pass_cnt", 32'(pass_cnt), 0);
        start = 1'b1;
        quiet = 1;
        repeat (8) begin
            @(negedge clk_50m);
            if (wr_en || busy) quiet = 0;
        end
        check("abort start_ignored", 32'(quiet), 1);
        start = 1'b0;
        fault_a = 0; fault_b = 0;

        // Reset mid-WRITE with start held high
        sdram_init_done = 1'b1;
        repeat (4) @(negedge clk_50m);
        mode = 2'd0; start = 1'b1;
        repeat (8) @(negedge clk_50m);
        check("rst in_write", 32'(wr_en), 1);
        reset_n = 1'b0;
        @(negedge clk_50m);
        check("rst outputs_zero", 32'(|{wr_en, wr_data, rd_en, busy, done, error_flag, error_cnt,
                                        first_err_idx, first_err_data, pass_cnt}), 0);
        reset_n = 1'b1;
        start = 1'b0;
        quiet = 1;
        repeat (6) begin
            @(negedge clk_50m);
            if (wr_en || busy) quiet = 0;
        end
        check("rst no_self_start", 32'(quiet), 1);
        run_pass(vecs[0], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_pattern_tester.md
Name: sdram_pattern_tester

Overview:
Parametrised SDRAM write/read-back tester placed between the SDRAM controller's user write/read ports and board status logic. Once SDRAM init is done it writes TEST_LEN words from a selectable pattern, reads them back and compares each word against the expected value, compensating for a configurable read latency. It reports a sticky error flag, a saturating error count, first-failure index and data, and a completed-pass count. Optional loop mode repeats passes for soak testing.

Parameters:
DATA_W, 16, data word width (must be ≥2)
TEST_LEN, 1024, words per pass (must be ≥2)
CNT_W, 11, index/counter width (must satisfy 2^CNT_W > TEST_LEN)
RD_LAT, 1, cycles from a rd_en cycle until its rd_data is valid (0 means same cycle)

Ports:
clk_50m  in  1  system clock
reset_n  in  1  reset; one clock, reset is synchronous and active-low
sdram_init_done  in  1  SDRAM init complete (asynchronous, synchronised internally)
start  in  1  start request, level-sampled
mode  in  2  pattern select, latched when start is accepted
loop_en  in  1  repeat passes until aborted
wr_en  out  1  write enable to controller
wr_data  out  DATA_W  write data
rd_en  out  1  read enable to controller
rd_data  in  DATA_W  read data
busy  out  1  pass in progress (WRITE or READ)
done  out  1  in DONE state
error_flag  out  1  sticky mismatch flag
error_cnt  out  16  mismatch count, saturates at 0xFFFF
first_err_idx  out  CNT_W  index of first mismatch
first_err_data  out  DATA_W  rd_data of first mismatch
pass_cnt  out  16  completed passes, saturates at 0xFFFF

Behaviour:
- Reset (reset_n low at an edge): all outputs 0, state IDLE, sync flops 0, latency pipeline cleared.
- sdram_init_done goes through a 2-flop synchroniser; init_s is the synchronised value.
- Pattern p(i) for index i = 1..TEST_LEN, by latched mode:
  - 0: i zero-extended or truncated to DATA_W.
  - 1: bitwise NOT of mode-0 value.
  - 2: walking one, 1 << ((i-1) mod DATA_W).
  - 3: checkerboard, odd i gives all 0x5 nibbles (...0101), even i gives all 0xA nibbles (...1010).
- States: IDLE, WRITE, READ, DONE.
  - IDLE/DONE -> WRITE: at edge N with start=1 and init_s=1. Latch mode. Clear error_flag, error_cnt, first_err_*, pass_cnt.
  - WRITE: wr_en=1 and wr_data=p(i) in cycles N+1..N+TEST_LEN, i ascending; wr_data=0 whenever wr_en=0.
  - READ: rd_en=1 in cycles N+TEST_LEN+1..N+2*TEST_LEN, i ascending.
  - Compare: the rd_en cycle for index i is driven by edge r_i. rd_data is compared with p(i) at edge r_i+1+RD_LAT, using an index/valid delay pipeline of depth RD_LAT+1.
  - READ -> DONE: on the edge of the last compare, whose result is included in that edge's stats update.
  - DONE with loop_en=1: DONE lasts one cycle. Then WRITE restarts at i=1 with mode unchanged; stats are not cleared. done is a one-cycle pulse per pass.
  - DONE with loop_en=0: hold DONE until start.
- pass_cnt increments on every DONE entry.
- busy=1 only in WRITE and READ.
- start while busy is ignored.
- Mismatch at a compare edge: error_flag<=1 (sticky); error_cnt+1 (saturating); first_err_idx/first_err_data captured only if error_flag was 0 before that edge.
- Abort: init_s=0 while in WRITE, READ or DONE:
  - Next state IDLE; wr_en/rd_en/busy/done are 0 from the following edge.
  - In-flight compares are discarded.
  - error/pass stats are retained.
- In IDLE, start is ignored while init_s=0.
- Wrap: the index counter never exceeds TEST_LEN; it returns to 1 at every WRITE/READ entry.

Test Plan:
Common bench setup: DATA_W=16, TEST_LEN=16, CNT_W=5, RD_LAT=2, memory model returning stored data with 2-cycle latency.
1. Init high, start at edge N, mode=0 -> wr_data 1..16 in cycles N+1..N+16; rd_en in cycles N+17..N+32; done=1 from edge N+35; error_flag=0; error_cnt=0; pass_cnt=1; busy=0.
2. Mode=2 -> wr_data 0x0001,0x0002,...,0x8000. Mode=3 -> 0x5555,0xAAAA alternating. Mode=1 -> 0xFFFE,0xFFFD,...,0xFFEF. All three -> error_cnt=0.
3. Model XORs 0x0100 onto read indices 5 and 9, mode 0 -> error_flag rises at compare edge for i=5; final error_cnt=2, first_err_idx=5, first_err_data=0x0105.
4. loop_en=1, clean model, 3 passes -> three one-cycle done pulses 35 cycles apart; pass_cnt=3. Then inject one fault in pass 4 -> error_cnt=1 and counting continues.
5. Drop sdram_init_done during READ -> rd_en low within 3 edges; state IDLE, busy=0, done=0, stats unchanged; start with init low -> no wr_en.
6. reset_n low for 1 edge mid-WRITE with start held high -> all outputs 0 at that edge; a new pass begins only via start after reset_n is high.
